complex_row_sequencer_left: RTL and testbench

//  Initiator for the left-side row decoder of the 4x4 RRAM tile array. Accepts one row-access

---
 rtl/complex_row_sequencer_left.sv | 182 ++++++++++++++++++
 tb/tb_complex_row_sequencer_left.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_row_sequencer_left.sv
// Left-side row-decoder sequencer: takes one row-access command, drives decoder mode/address,
// and times CWL_left as setup -> pulse -> hold before a one-cycle done strobe.
module complex_row_sequencer_left #(
  parameter int Narray    = 2,
  parameter int PW        = 8,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [Narray-1:0] cmd_row,
  input  logic [PW-1:0]     cmd_pulse_len,
  output logic              busy,
  output logic              done,
  output logic              CWL_left,
  output logic              inference,
  output logic              read_1,
  output logic              read_8,
  output logic [Narray-1:0] adr_full_row
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_ROW   = 2'b00;
  localparam logic [1:0] OP_READ1 = 2'b01;
  localparam logic [1:0] OP_READ8 = 2'b10;
  localparam logic [1:0] OP_INFER = 2'b11;

  // One down-counter times every phase, so it must hold both a full pulse length and the
  // longer of the setup/hold counts.
  localparam int PH_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CW     = (PW > PH_W) ? PW : PH_W;

  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [PW-1:0]     len_q, len_d;
  logic              ready_d, busy_d, done_d, cwl_d, inf_d, r1_d, r8_d;
  logic [Narray-1:0] adr_d;
  logic              last_cycle;

  assign last_cycle = (cnt_q == CNT_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      len_q        <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      CWL_left     <= 1'b0;
      inference    <= 1'b0;
      read_1       <= 1'b0;
      read_8       <= 1'b0;
      adr_full_row <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      len_q        <= len_d;
      cmd_ready    <= ready_d;
      busy         <= busy_d;
      done         <= done_d;
      CWL_left     <= cwl_d;
      inference    <= inf_d;
      read_1       <= r1_d;
      read_8       <= r8_d;
      adr_full_row <= adr_d;
    end
  end

  // Next-state and next-output logic; outputs are registered so they change on state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    len_d   = len_q;
    ready_d = cmd_ready;
    busy_d  = busy;
    done_d  = 1'b0;
    cwl_d   = CWL_left;
    inf_d   = inference;
    r1_d    = read_1;
    r8_d    = read_8;
    adr_d   = adr_full_row;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
          op_d    = cmd_op;
          len_d   = cmd_pulse_len;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          r1_d    = (cmd_op == OP_READ1);
          r8_d    = (cmd_op == OP_READ8);
          inf_d   = (cmd_op == OP_INFER);
          adr_d   = cmd_row;
        end
      end
      SETUP: begin
        if (last_cycle) begin
          // Inference never fires the word line, so it skips straight to the hold window.
          if (op_q != OP_INFER) begin
            state_d = PULSE;
            cnt_d   = (len_q == '0) ? CNT_ONE : CW'(len_q);
            cwl_d   = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PULSE: begin
        if (last_cycle) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          cwl_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        if (last_cycle) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
          inf_d   = 1'b0;
          r1_d    = 1'b0;
          r8_d    = 1'b0;
          adr_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cwl_d   = 1'b0;
        inf_d   = 1'b0;
        r1_d    = 1'b0;
        r8_d    = 1'b0;
        adr_d   = '0;
      end
    endcase
  end

  // Decoder-facing invariants: one mode at most, and the word line only fires inside PULSE.
  a_mode_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0({inference, read_8, read_1}));
  a_cwl_in_pulse : assert property (@(posedge clk) disable iff (reset)
    CWL_left |-> (state_q == PULSE));
  a_ready_idle : assert property (@(posedge clk) disable iff (reset)
    cmd_ready == (state_q == IDLE));

endmodule

// File: tb/tb_complex_row_sequencer_left.sv
// Scoreboard bench for complex_row_sequencer_left: expected access timing is queued at issue
// and compared against the observed CWL_left/done/mode behaviour.
module tb_complex_row_sequencer_left;

  localparam int NARRAY = 2;
  localparam int PW     = 8;
  localparam int SETUP  = 2;
  localparam int HOLD   = 2;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [NARRAY-1:0] cmd_row;
  logic [PW-1:0]     cmd_pulse_len;
  logic              busy;
  logic              done;
  logic              CWL_left;
  logic              inference;
  logic              read_1;
  logic              read_8;
  logic [NARRAY-1:0] adr_full_row;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int                start;
    int                width;
    int                done_at;
    logic [2:0]        mode;
    logic [NARRAY-1:0] adr;
    bit                clean;
  } acc_t;

  acc_t sb[$];

  complex_row_sequencer_left #(
    .Narray(NARRAY), .PW(PW), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_pulse_len(cmd_pulse_len),
    .busy(busy), .done(done), .CWL_left(CWL_left), .inference(inference),
    .read_1(read_1), .read_8(read_8), .adr_full_row(adr_full_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference timing: mode bits are {inference, read_8, read_1}, cycles counted from accept.
  function automatic acc_t model(logic [1:0] op, logic [NARRAY-1:0] row, logic [PW-1:0] len);
    acc_t e;
    int p;
    p = (op == 2'b11) ? 0 : ((len == 0) ? 1 : int'(len));
    e.start   = (op == 2'b11) ? -1 : SETUP + 1;
    e.width   = p;
    e.done_at = SETUP + p + HOLD + 1;
    case (op)
      2'b01:   e.mode = 3'b001;
      2'b10:   e.mode = 3'b010;
      2'b11:   e.mode = 3'b100;
      default: e.mode = 3'b000;
    endcase
    e.adr   = row;
    e.clean = 1'b1;
    return e;
  endfunction

  // Waits (bounded) for cmd_ready, accepts one command and queues its expectation.
  task automatic send(input logic [1:0] op, input logic [NARRAY-1:0] row,
                      input logic [PW-1:0] len, input bit keep_valid,
                      output bit ok, output int waited);
    cmd_op        = op;
    cmd_row       = row;
    cmd_pulse_len = len;
    cmd_valid     = 1'b1;
    ok            = 1'b0;
    waited        = 0;
    sb.push_back(model(op, row, len));
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
      waited++;
    end
    step();
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  // Records one access starting at accept+1 and returns in the done cycle (or on timeout).
  task automatic observe(output acc_t o);
    logic [2:0]        m0;
    logic [NARRAY-1:0] a0;
    bit                prev;
    int                rises;
    o.start   = -1;
    o.width   = 0;
    o.done_at = 0;
    o.clean   = 1'b1;
    m0        = {inference, read_8, read_1};
    a0        = adr_full_row;
    o.mode    = m0;
    o.adr     = a0;
    prev      = 1'b0;
    rises     = 0;
    for (int n = 1; n <= 600; n++) begin
      if (CWL_left === 1'b1) begin
        if (!prev) begin
          rises++;
          if (o.start == -1) o.start = n;
        end
        o.width++;
      end
      prev = (CWL_left === 1'b1);
      if (busy !== 1'b1 || cmd_ready !== 1'b0) o.clean = 1'b0;
      if (done === 1'b1) begin
        o.done_at = n;
        if ({inference, read_8, read_1, adr_full_row, CWL_left} !== '0) o.clean = 1'b0;
        break;
      end
      if ({inference, read_8, read_1} !== m0 || adr_full_row !== a0) o.clean = 1'b0;
      step();
    end
    if (o.done_at == 0 || rises > 1) o.clean = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_row   = '0;
    cmd_pulse_len = '0;
    repeat (3) step();
    checks++;
    if ({cmd_ready, busy, done, CWL_left, inference, read_1, read_8, adr_full_row} !== 9'b1_0000_0000) begin
      failures++;
      $display("[TB] FAIL reset_values: got %b, expected %b",
               {cmd_ready, busy, done, CWL_left, inference, read_1, read_8, adr_full_row}, 9'b1_0000_0000);
    end
    reset = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got ready=%b busy=%b, expected ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_row_access();
    acc_t o, e;
    bit   ok;
    int   w;
    send(2'b00, 2'd2, 8'd5, 1'b0, ok, w);
    observe(o);
    e = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL t1_accept: got not accepted, expected accepted"); end
    checks++;
    if (o.start != e.start || o.width != e.width) begin
      failures++;
      $display("[TB] FAIL t1_pulse: got start=%0d width=%0d, expected start=%0d width=%0d", o.start, o.width, e.start, e.width);
    end
    checks++;
    if (o.done_at != e.done_at) begin failures++; $display("[TB] FAIL t1_done: got %0d, expected %0d", o.done_at, e.done_at); end
    checks++;
    if ({o.mode, o.adr} !== {e.mode, e.adr}) begin
      failures++;
      $display("[TB] FAIL t1_mode_adr: got %b/%0d, expected %b/%0d", o.mode, o.adr, e.mode, e.adr);
    end
    checks++;
    if (o.clean !== e.clean) begin failures++; $display("[TB] FAIL t1_stable: got %b, expected %b", o.clean, e.clean); end
    step();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL t1_after_done: got done=%b ready=%b, expected done=0 ready=1", done, cmd_ready);
    end
  endtask

  task automatic test_read8_zero_len();
    acc_t o, e;
    bit   ok;
    int   w;
    send(2'b10, 2'd1, 8'd0, 1'b0, ok, w);
    observe(o);
    e = sb.pop_front();
    checks++;
    if (o.start != e.start || o.width != e.width) begin
      failures++;
      $display("[TB] FAIL t2_pulse: got start=%0d width=%0d, expected start=%0d width=%0d", o.start, o.width, e.start, e.width);
    end
    checks++;
    if (o.done_at != e.done_at) begin failures++; $display("[TB] FAIL t2_done: got %0d, expected %0d", o.done_at, e.done_at); end
    checks++;
    if ({o.mode, o.adr, o.clean} !== {e.mode, e.adr, e.clean}) begin
      failures++;
      $display("[TB] FAIL t2_mode: got %b/%0d/%b, expected %b/%0d/%b", o.mode, o.adr, o.clean, e.mode, e.adr, e.clean);
    end
  endtask

  task automatic test_inference();
    acc_t o, e;
    bit   ok;
    int   w;
    send(2'b11, 2'd3, 8'd9, 1'b0, ok, w);
    observe(o);
    e = sb.pop_front();
    checks++;
    if (o.width != 0 || o.start != -1) begin
      failures++;
      $display("[TB] FAIL t3_no_cwl: got start=%0d width=%0d, expected start=-1 width=0", o.start, o.width);
    end
    checks++;
    if (o.done_at != e.done_at) begin failures++; $display("[TB] FAIL t3_done: got %0d, expected %0d", o.done_at, e.done_at); end
    checks++;
    if ({o.mode, o.adr, o.clean} !== {e.mode, e.adr, e.clean}) begin
      failures++;
      $display("[TB] FAIL t3_mode: got %b/%0d/%b, expected %b/%0d/%b", o.mode, o.adr, o.clean, e.mode, e.adr, e.clean);
    end
  endtask

  task automatic test_back_to_back();
    acc_t o, e;
    bit   ok;
    int   w;
    send(2'b00, 2'd1, 8'd3, 1'b1, ok, w);
    // A competing command stays asserted for the whole first access and must be ignored.
    cmd_op        = 2'b01;
    cmd_row       = 2'd3;
    cmd_pulse_len = 8'd2;
    observe(o);
    e = sb.pop_front();
    checks++;
    if (o.done_at != e.done_at || o.width != e.width) begin
      failures++;
      $display("[TB] FAIL t4_first_timing: got done=%0d width=%0d, expected done=%0d width=%0d", o.done_at, o.width, e.done_at, e.width);
    end
    checks++;
    if ({o.mode, o.adr, o.clean} !== {e.mode, e.adr, e.clean}) begin
      failures++;
      $display("[TB] FAIL t4_first_outputs: got %b/%0d/%b, expected %b/%0d/%b", o.mode, o.adr, o.clean, e.mode, e.adr, e.clean);
    end
    send(2'b01, 2'd3, 8'd2, 1'b0, ok, w);
    checks++;
    if (!ok || w != 1) begin
      failures++;
      $display("[TB] FAIL t4_second_accept: got wait=%0d ok=%b, expected wait=1 ok=1", w, ok);
    end
    observe(o);
    e = sb.pop_front();
    checks++;
    if (o.done_at != e.done_at || o.width != e.width || {o.mode, o.adr, o.clean} !== {e.mode, e.adr, e.clean}) begin
      failures++;
      $display("[TB] FAIL t4_second_access: got done=%0d width=%0d mode=%b adr=%0d, expected done=%0d width=%0d mode=%b adr=%0d",
               o.done_at, o.width, o.mode, o.adr, e.done_at, e.width, e.mode, e.adr);
    end
  endtask

  task automatic test_reset_abort();
    acc_t e;
    bit   ok;
    bit   saw_done;
    int   w;
    send(2'b01, 2'd2, 8'd20, 1'b0, ok, w);
    e = sb.pop_front();
    repeat (3) step();
    checks++;
    if (CWL_left !== 1'b1) begin failures++; $display("[TB] FAIL t5_in_pulse: got CWL_left=%b, expected 1", CWL_left); end
    reset = 1'b1;
    step();
    checks++;
    if ({CWL_left, read_1, cmd_ready, busy, done} !== 5'b00100) begin
      failures++;
      $display("[TB] FAIL t5_abort: got %b, expected %b", {CWL_left, read_1, cmd_ready, busy, done}, 5'b00100);
    end
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      step();
      if (done === 1'b1 || CWL_left === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin failures++; $display("[TB] FAIL t5_no_done: got activity after abort for row %0d, expected none", e.adr); end
  endtask

  task automatic test_max_len();
    acc_t o, e;
    bit   ok;
    int   w;
    send(2'b00, 2'd3, 8'd255, 1'b0, ok, w);
    observe(o);
    e = sb.pop_front();
    checks++;
    if (o.width != e.width || o.start != e.start) begin
      failures++;
      $display("[TB] FAIL t6_width: got start=%0d width=%0d, expected start=%0d width=%0d", o.start, o.width, e.start, e.width);
    end
    checks++;
    if (o.done_at != e.done_at || o.clean !== e.clean) begin
      failures++;
      $display("[TB] FAIL t6_done: got %0d/%b, expected %0d/%b", o.done_at, o.clean, e.done_at, e.clean);
    end
  endtask

  task automatic test_random();
    acc_t o, e;
    bit   ok;
    int   w;
    for (int k = 0; k < 6; k++) begin
      send(2'($urandom_range(0, 3)), NARRAY'($urandom_range(0, 3)), PW'($urandom_range(0, 12)), 1'b0, ok, w);
      observe(o);
      e = sb.pop_front();
      checks++;
      if (o.start != e.start || o.width != e.width || o.done_at != e.done_at) begin
        failures++;
        $display("[TB] FAIL rand_timing_%0d: got start=%0d width=%0d done=%0d, expected start=%0d width=%0d done=%0d",
                 k, o.start, o.width, o.done_at, e.start, e.width, e.done_at);
      end
      checks++;
      if ({o.mode, o.adr, o.clean} !== {e.mode, e.adr, e.clean}) begin
        failures++;
        $display("[TB] FAIL rand_outputs_%0d: got %b/%0d/%b, expected %b/%0d/%b", k, o.mode, o.adr, o.clean, e.mode, e.adr, e.clean);
      end
    end
  endtask

  initial begin
    test_reset();
    test_row_access();
    test_read8_zero_len();
    test_inference();
    test_back_to_back();
    test_reset_abort();
    test_max_len();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
